// File: rtl/imem_arbiter_pkg.sv
// Shared constants and FSM encoding for the instruction-memory arbiter.
// Holds the code-window bounds and the exception code returned on illegal fetches.
package imem_arbiter_pkg;

    localparam logic [31:0] IMEM_BASE     = 32'h0000_3000;
    localparam logic [31:0] IMEM_LIMIT    = 32'h0000_4ffc;
    localparam int          IMEM_IDX_W    = 12;
    localparam int          IMEM_MAX_WAIT = 8;
    localparam logic [4:0]  EXC_ADEL      = 5'd4;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/imem_addr_check.sv
// Code-window check for one requester: legal flag and memory word index.
// The index is only meaningful when legal is high.
module imem_addr_check
    import imem_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE  = IMEM_BASE,
    parameter logic [31:0] LIMIT = IMEM_LIMIT,
    parameter int          IDX_W = IMEM_IDX_W
) (
    input  logic [31:0]      addr,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);

    assign legal = (addr >= BASE) && (addr <= LIMIT) && (addr[1:0] == 2'b00);
    assign idx   = IDX_W'((addr - BASE) >> 2);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between the fetch stage and the loader.
// Fetch has fixed priority; a starved loader is forced through, and a locked loader owns the port.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE     = IMEM_BASE,
    parameter logic [31:0] LIMIT    = IMEM_LIMIT,
    parameter int          IDX_W    = IMEM_IDX_W,
    parameter int          MAX_WAIT = IMEM_MAX_WAIT
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             f_req,
    input  logic [31:0]      f_addr,
    input  logic             f_flush,
    output logic             f_gnt,
    output logic             f_rvalid,
    output logic [31:0]      f_rdata,
    output logic [4:0]       f_excCode,

    input  logic             l_req,
    input  logic             l_we,
    input  logic             l_lock,
    input  logic [31:0]      l_addr,
    input  logic [31:0]      l_wdata,
    output logic             l_gnt,
    output logic             l_rvalid,
    output logic [31:0]      l_rdata,
    output logic             l_err,

    output logic             m_en,
    output logic             m_we,
    output logic [IDX_W-1:0] m_addr,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    arb_state_e        state;
    arb_state_e        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;

    logic             f_legal;
    logic             l_legal;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] l_idx;

    logic fetch_wants;
    logic starved;
    logic f_grant;
    logic l_grant;
    logic f_access;
    logic l_access;

    logic f_rvalid_q;
    logic f_ok_q;
    logic l_rvalid_q;
    logic l_ok_q;
    logic l_rd_q;

    imem_addr_check #(
        .BASE  (BASE),
        .LIMIT (LIMIT),
        .IDX_W (IDX_W)
    ) u_fetch_check (
        .addr  (f_addr),
        .legal (f_legal),
        .idx   (f_idx)
    );

    imem_addr_check #(
        .BASE  (BASE),
        .LIMIT (LIMIT),
        .IDX_W (IDX_W)
    ) u_loader_check (
        .addr  (l_addr),
        .legal (l_legal),
        .idx   (l_idx)
    );

    assign fetch_wants = f_req && !f_flush;
    assign starved     = (wait_cnt >= WAIT_W'(MAX_WAIT));

    // Grant selection and next state; grants are forced low while reset is held.
    always_comb begin
        state_next = state;
        f_grant    = 1'b0;
        l_grant    = 1'b0;

        if (state == LOCK && l_lock) begin
            l_grant = l_req;
        end else begin
            l_grant    = l_req && (starved || !fetch_wants);
            f_grant    = fetch_wants && !l_grant;
            state_next = (l_grant && l_lock) ? LOCK : ARB;
        end

        if (reset) begin
            f_grant = 1'b0;
            l_grant = 1'b0;
        end
    end

    always_comb begin
        wait_next = '0;
        if (l_req && !l_grant) begin
            wait_next = starved ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    assign f_gnt    = f_grant;
    assign l_gnt    = l_grant;
    assign f_access = f_grant && f_legal;
    assign l_access = l_grant && l_legal;

    assign m_en    = f_access || l_access;
    assign m_we    = l_access && l_we;
    assign m_addr  = l_access ? l_idx : (f_access ? f_idx : '0);
    assign m_wdata = m_we ? l_wdata : 32'h0;

    // Response flags follow the memory's one-cycle read; an in-flight response dies with reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_rvalid_q <= 1'b0;
            f_ok_q     <= 1'b0;
            l_rvalid_q <= 1'b0;
            l_ok_q     <= 1'b0;
            l_rd_q     <= 1'b0;
        end else begin
            f_rvalid_q <= f_grant;
            f_ok_q     <= f_legal;
            l_rvalid_q <= l_grant;
            l_ok_q     <= l_legal;
            l_rd_q     <= l_access && !l_we;
        end
    end

    assign f_rvalid  = f_rvalid_q;
    assign f_rdata   = (f_rvalid_q && f_ok_q) ? m_rdata : 32'h0;
    assign f_excCode = (f_rvalid_q && !f_ok_q) ? EXC_ADEL : 5'd0;

    assign l_rvalid = l_rvalid_q;
    assign l_rdata  = l_rd_q ? m_rdata : 32'h0;
    assign l_err    = l_rvalid_q && !l_ok_q;

    a_one_grant: assert property (@(posedge clk) disable iff (reset) !(f_gnt && l_gnt));
    a_we_has_en: assert property (@(posedge clk) disable iff (reset) m_we |-> m_en);
    a_lock_no_fetch: assert property (@(posedge clk) disable iff (reset)
        (state == LOCK && l_lock) |-> !f_gnt);

endmodule
